// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and one-hot helpers for the voting-machine front end.
package vm_pkg;

    localparam int unsigned NUM_CAND = 4;

    typedef logic [1:0]          cand_t;
    typedef logic [NUM_CAND-1:0] press_t;

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        COMMIT,
        WAIT_RELEASE,
        REJECT
    } state_t;

    function automatic logic is_multi(input press_t v);
        return (v & (v - press_t'(1))) != '0;
    endfunction

    function automatic logic is_onehot(input press_t v);
        return (v != '0) && !is_multi(v);
    endfunction

    // button1 -> 0 ... button4 -> 3; non-one-hot inputs map to 0
    function automatic cand_t onehot_to_idx(input press_t v);
        case (v)
            press_t'(4'b0010): return cand_t'(1);
            press_t'(4'b0100): return cand_t'(2);
            press_t'(4'b1000): return cand_t'(3);
            default:           return cand_t'(0);
        endcase
    endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Button/vote/display bundle between the candidate panel and the vote counters.
interface vote_session_ctrl_if #(
    parameter int unsigned COUNT_W = 8
);
    import vm_pkg::*;

    logic               mode;
    logic               button1;
    logic               button2;
    logic               button3;
    logic               button4;
    logic               vote_valid;
    cand_t              vote_sel;
    logic               reject;
    logic               busy;
    cand_t              res_sel;
    logic [COUNT_W-1:0] total_votes;

    modport master (
        output mode, button1, button2, button3, button4,
        input  vote_valid, vote_sel, reject, busy, res_sel, total_votes
    );

    modport slave (
        input  mode, button1, button2, button3, button4,
        output vote_valid, vote_sel, reject, busy, res_sel, total_votes
    );

endinterface

// File: rtl/vote_debounce_cnt.sv
// Debounce qualification counter: start loads 1, inc counts up to TERMINAL.
module vote_debounce_cnt #(
    parameter int unsigned TERMINAL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inc,
    output logic last
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= 8'd1;
        end else if (inc && (cnt != 8'(TERMINAL))) begin
            cnt <= cnt + 8'd1;
        end
    end

    // High when the next matching sample completes the qualification
    assign last = (cnt == 8'(TERMINAL - 1));

endmodule

// File: rtl/vote_session_ctrl.sv
// Qualifies candidate button presses into single vote strobes and steers
// the result display select.
module vote_session_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    vote_session_ctrl_if.slave  bus
);

    state_t             state;
    press_t             press_q;
    press_t             latched;
    logic               vote_valid;
    cand_t              vote_sel;
    logic               reject;
    cand_t              res_sel;
    logic [COUNT_W-1:0] total;
    logic               cnt_start;
    logic               cnt_inc;
    logic               cnt_last;
    logic               match;

    always_comb begin
        match     = !bus.mode && (press_q == latched);
        cnt_start = (state == IDLE) && !bus.mode && is_onehot(press_q);
        cnt_inc   = (state == QUALIFY) && match;
    end

    vote_debounce_cnt #(
        .TERMINAL (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .start (cnt_start),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            press_q    <= '0;
            latched    <= '0;
            vote_valid <= 1'b0;
            vote_sel   <= '0;
            reject     <= 1'b0;
            res_sel    <= '0;
            total      <= '0;
        end else begin
            press_q    <= {bus.button4, bus.button3, bus.button2, bus.button1};
            vote_valid <= 1'b0;

            if (bus.mode && is_onehot(press_q)) begin
                res_sel <= onehot_to_idx(press_q);
            end

            case (state)
                IDLE: begin
                    if (!bus.mode) begin
                        if (is_multi(press_q)) begin
                            state  <= REJECT;
                            reject <= 1'b1;
                        end else if (press_q != '0) begin
                            latched <= press_q;
                            state   <= QUALIFY;
                        end
                    end
                end
                QUALIFY: begin
                    if (is_multi(press_q)) begin
                        state  <= REJECT;
                        reject <= 1'b1;
                    end else if (!match) begin
                        state <= IDLE;
                    end else if (cnt_last) begin
                        state <= COMMIT;
                    end
                end
                // Strobe is registered on the way out, so it lines up with
                // the first WAIT_RELEASE cycle
                COMMIT: begin
                    vote_valid <= 1'b1;
                    vote_sel   <= onehot_to_idx(latched);
                    if (total != '1) begin
                        total <= total + COUNT_W'(1);
                    end
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (press_q == '0) begin
                        state <= IDLE;
                    end
                end
                REJECT: begin
                    if (press_q == '0) begin
                        state  <= IDLE;
                        reject <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    reject <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vote_valid  = vote_valid;
    assign bus.vote_sel    = vote_sel;
    assign bus.reject      = reject;
    assign bus.busy        = (state != IDLE);
    assign bus.res_sel     = res_sel;
    assign bus.total_votes = total;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: a COUNT_W=8 instance plus a
// COUNT_W=2 instance sharing the same buttons for the saturation scenario.
module tb_vote_session_ctrl;
    import vm_pkg::*;

    localparam int unsigned D = 10;

    typedef struct {
        cand_t sel;
        int    total;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int pulses    = 0;
    int pulses2   = 0;
    int exp_total = 0;
    int exp_total2 = 0;

    exp_t q1[$];
    exp_t q2[$];

    vote_session_ctrl_if #(.COUNT_W(8)) bus ();
    vote_session_ctrl_if #(.COUNT_W(2)) bus2 ();

    vote_session_ctrl #(.DEBOUNCE_CYCLES(D), .COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vote_session_ctrl #(.DEBOUNCE_CYCLES(D), .COUNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.mode    = bus.mode;
    assign bus2.button1 = bus.button1;
    assign bus2.button2 = bus.button2;
    assign bus2.button3 = bus.button3;
    assign bus2.button4 = bus.button4;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.vote_valid === 1'b1) begin
            pulses++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL vote_unexpected: got sel=%0d total=%0d at cycle %0d, required no strobe",
                         bus.vote_sel, bus.total_votes, cyc);
            end else begin
                e = q1.pop_front();
                if (bus.vote_sel !== e.sel || bus.total_votes !== 8'(e.total) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL vote_strobe: got sel=%0d total=%0d cycle=%0d, required sel=%0d total=%0d cycle=%0d",
                             bus.vote_sel, bus.total_votes, cyc, e.sel, e.total, e.cyc);
                end
            end
        end
        if (bus2.vote_valid === 1'b1) begin
            pulses2++;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL vote2_unexpected: got sel=%0d total=%0d at cycle %0d, required no strobe",
                         bus2.vote_sel, bus2.total_votes, cyc);
            end else begin
                e = q2.pop_front();
                if (bus2.vote_sel !== e.sel || bus2.total_votes !== 2'(e.total) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL vote2_strobe: got sel=%0d total=%0d cycle=%0d, required sel=%0d total=%0d cycle=%0d",
                             bus2.vote_sel, bus2.total_votes, cyc, e.sel, e.total, e.cyc);
                end
            end
        end
    end

    task automatic set_button(input cand_t idx, input logic val);
        case (idx)
            2'd0:    bus.button1 = val;
            2'd1:    bus.button2 = val;
            2'd2:    bus.button3 = val;
            default: bus.button4 = val;
        endcase
    endtask

    // Strobe appears D+2 posedges after the negedge the button is driven
    task automatic expect_vote(input cand_t idx);
        exp_t e;
        exp_total  = (exp_total >= 255) ? 255 : exp_total + 1;
        exp_total2 = (exp_total2 >= 3) ? 3 : exp_total2 + 1;
        e.sel   = idx;
        e.total = exp_total;
        e.cyc   = cyc + int'(D) + 2;
        q1.push_back(e);
        e.total = exp_total2;
        q2.push_back(e);
    endtask

    task automatic hold(input cand_t idx, input int n, input bit votes);
        set_button(idx, 1'b1);
        if (votes) expect_vote(idx);
        repeat (n) @(negedge clk);
        set_button(idx, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.vote_valid !== 1'b0 || bus.vote_sel !== 2'd0 || bus.reject !== 1'b0 ||
            bus.busy !== 1'b0 || bus.res_sel !== 2'd0 || bus.total_votes !== 8'd0 ||
            bus2.total_votes !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got vv=%b sel=%0d rej=%b busy=%b res=%0d tot=%0d tot2=%0d, required all 0",
                     bus.vote_valid, bus.vote_sel, bus.reject, bus.busy, bus.res_sel,
                     bus.total_votes, bus2.total_votes);
        end
        rst = 1'b0;
        exp_total = 0;
        exp_total2 = 0;
        @(negedge clk);
    endtask

    task automatic test_clean_vote();
        int p0 = pulses;
        hold(2'd0, 20, 1'b1);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL clean_pulses: got %0d, required 1", pulses - p0);
        end
        checks++;
        if (bus.total_votes !== 8'(exp_total) || bus.vote_sel !== 2'd0) begin
            errors++;
            $display("FAIL clean_total: got total=%0d sel=%0d, required total=%0d sel=0",
                     bus.total_votes, bus.vote_sel, exp_total);
        end
    endtask

    task automatic test_bounce();
        int p0 = pulses;
        hold(2'd1, 5, 1'b0);
        hold(2'd1, 20, 1'b1);
        checks++;
        if (pulses - p0 != 1 || bus.total_votes !== 8'(exp_total) || bus.vote_sel !== 2'd1) begin
            errors++;
            $display("FAIL bounce: got pulses=%0d total=%0d sel=%0d, required pulses=1 total=%0d sel=1",
                     pulses - p0, bus.total_votes, bus.vote_sel, exp_total);
        end
    endtask

    task automatic test_boundary();
        int p0 = pulses;
        hold(2'd0, int'(D) - 1, 1'b0);
        hold(2'd0, int'(D), 1'b1);
        checks++;
        if (pulses - p0 != 1 || bus.total_votes !== 8'(exp_total)) begin
            errors++;
            $display("FAIL boundary_hold: got pulses=%0d total=%0d, required pulses=1 total=%0d",
                     pulses - p0, bus.total_votes, exp_total);
        end
    endtask

    task automatic test_simultaneous();
        int p0 = pulses;
        int bad = 0;
        bus.button2 = 1'b1;
        bus.button3 = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            if (bus.reject !== 1'b1 || bus.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        bus.button2 = 1'b0;
        bus.button3 = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reject_hold: got %0d cycles without reject, required 0", bad);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.reject !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_release: got reject=%b busy=%b, required 0 0", bus.reject, bus.busy);
        end
        checks++;
        if (pulses - p0 != 0 || bus.total_votes !== 8'(exp_total)) begin
            errors++;
            $display("FAIL reject_novote: got pulses=%0d total=%0d, required pulses=0 total=%0d",
                     pulses - p0, bus.total_votes, exp_total);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_result_mode();
        int p0 = pulses;
        bus.mode = 1'b1;
        hold(2'd1, 20, 1'b0);
        checks++;
        if (bus.res_sel !== 2'd1) begin
            errors++;
            $display("FAIL result_sel1: got %0d, required 1", bus.res_sel);
        end
        set_button(2'd2, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.res_sel !== 2'd2 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL result_sel2: got res_sel=%0d busy=%b, required 2 0", bus.res_sel, bus.busy);
        end
        repeat (17) @(negedge clk);
        set_button(2'd2, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (pulses - p0 != 0 || bus.total_votes !== 8'(exp_total) || bus.res_sel !== 2'd2) begin
            errors++;
            $display("FAIL result_novote: got pulses=%0d total=%0d res_sel=%0d, required 0 %0d 2",
                     pulses - p0, bus.total_votes, bus.res_sel, exp_total);
        end
        bus.mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode_abort_reset();
        int p0 = pulses;
        set_button(2'd2, 1'b1);
        repeat (4) @(negedge clk);
        bus.mode = 1'b1;
        repeat (16) @(negedge clk);
        set_button(2'd2, 1'b0);
        repeat (4) @(negedge clk);
        bus.mode = 1'b0;
        checks++;
        if (pulses - p0 != 0 || bus.total_votes !== 8'(exp_total)) begin
            errors++;
            $display("FAIL abort_novote: got pulses=%0d total=%0d, required 0 %0d",
                     pulses - p0, bus.total_votes, exp_total);
        end
        set_button(2'd2, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.vote_valid !== 1'b0 || bus.vote_sel !== 2'd0 || bus.reject !== 1'b0 ||
            bus.busy !== 1'b0 || bus.res_sel !== 2'd0 || bus.total_votes !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state: got vv=%b sel=%0d rej=%b busy=%b res=%0d tot=%0d, required all 0",
                     bus.vote_valid, bus.vote_sel, bus.reject, bus.busy, bus.res_sel, bus.total_votes);
        end
        exp_total = 0;
        exp_total2 = 0;
        rst = 1'b0;
        set_button(2'd2, 1'b0);
        repeat (14) @(negedge clk);
        checks++;
        if (pulses - p0 != 0 || bus.total_votes !== 8'd0) begin
            errors++;
            $display("FAIL midreset_novote: got pulses=%0d total=%0d, required 0 0",
                     pulses - p0, bus.total_votes);
        end
    endtask

    task automatic test_saturation();
        int sat_exp[5] = '{1, 2, 3, 3, 3};
        int p0 = pulses2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
        exp_total2 = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            hold(2'd3, 12, 1'b1);
            checks++;
            if (bus2.total_votes !== 2'(sat_exp[i])) begin
                errors++;
                $display("FAIL sat_total[%0d]: got %0d, required %0d", i, bus2.total_votes, sat_exp[i]);
            end
        end
        checks++;
        if (pulses2 - p0 != 5 || bus.total_votes !== 8'd5) begin
            errors++;
            $display("FAIL sat_pulses: got pulses=%0d wide_total=%0d, required 5 5",
                     pulses2 - p0, bus.total_votes);
        end
    endtask

    initial begin
        bus.mode    = 1'b0;
        bus.button1 = 1'b0;
        bus.button2 = 1'b0;
        bus.button3 = 1'b0;
        bus.button4 = 1'b0;
        @(negedge clk);

        test_reset();
        test_clean_vote();
        test_bounce();
        test_boundary();
        test_simultaneous();
        test_result_mode();
        test_mode_abort_reset();
        test_saturation();

        repeat (4) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL missing_votes: got %0d/%0d pending expectations, required 0/0",
                     q1.size(), q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
